// File: rtl/wb_write_sequencer.sv
// Write-back sequencer: selects the write-back data and drives the single
// register file write port. An instruction with two destinations takes two
// cycles. A is written first, B is held for one cycle, and upstream is stalled
// for that cycle. Writes to r0 are discarded.
// Optional feature macro: WB_FWD_EN adds the combinational forwarding outputs
// fwd_valid / fwd_addr / fwd_data. These show the write that is in flight.
module wb_write_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      valid_in,
    input  logic                      write_back_mux_sel_in,
    input  logic [DATA_WIDTH-1:0]     alu_data_in,
    input  logic [DATA_WIDTH-1:0]     mem_data_in,
    input  logic [DATA_WIDTH-1:0]     hi_data_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_a_wr_addr_in,
    input  logic [REG_ADDR_WIDTH-1:0] reg_b_wr_addr_in,
    input  logic                      reg_a_wr_en_in,
    input  logic                      reg_b_wr_en_in,
    output logic                      ready_out,
    output logic                      rf_wr_en,
    output logic [REG_ADDR_WIDTH-1:0] rf_wr_addr,
    output logic [DATA_WIDTH-1:0]     rf_wr_data
`ifdef WB_FWD_EN
    ,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
    output logic [DATA_WIDTH-1:0]     fwd_data
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        WRITE_B = 1'b1
    } state_t;

    state_t                    state_reg;
    state_t                    state_next;
    logic [REG_ADDR_WIDTH-1:0] pend_addr_reg;
    logic [DATA_WIDTH-1:0]     pend_data_reg;

    logic                      wr_en_next;
    logic [REG_ADDR_WIDTH-1:0] wr_addr_next;
    logic [DATA_WIDTH-1:0]     wr_data_next;
    logic                      pend_load;

    logic                      eff_a;
    logic                      eff_b;
    logic                      same_addr;
    logic [DATA_WIDTH-1:0]     a_data;

    // Effective write requests. A write to r0 is never a real request.
    assign eff_a     = valid_in && reg_a_wr_en_in && (reg_a_wr_addr_in != '0);
    assign eff_b     = valid_in && reg_b_wr_en_in && (reg_b_wr_addr_in != '0);
    assign same_addr = (reg_a_wr_addr_in == reg_b_wr_addr_in);
    assign a_data    = write_back_mux_sel_in ? mem_data_in : alu_data_in;
    assign ready_out = (state_reg == IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. Only a dual write to two different registers needs the extra cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (eff_a && eff_b && !same_addr) state_next = WRITE_B;
            WRITE_B: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next write-port values and pending-B capture. Address and data hold when idle.
    always_comb begin
        wr_en_next   = 1'b0;
        wr_addr_next = rf_wr_addr;
        wr_data_next = rf_wr_data;
        pend_load    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (eff_b && (!eff_a || same_addr)) begin
                    // B alone, or both to one register: B wins and there is no stall
                    wr_en_next   = 1'b1;
                    wr_addr_next = reg_b_wr_addr_in;
                    wr_data_next = hi_data_in;
                end else if (eff_a) begin
                    wr_en_next   = 1'b1;
                    wr_addr_next = reg_a_wr_addr_in;
                    wr_data_next = a_data;
                    pend_load    = eff_b;
                end
            end
            WRITE_B: begin
                wr_en_next   = 1'b1;
                wr_addr_next = pend_addr_reg;
                wr_data_next = pend_data_reg;
            end
            default: ;
        endcase
    end

    // Registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wr_en   <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
        end else begin
            rf_wr_en   <= wr_en_next;
            rf_wr_addr <= wr_addr_next;
            rf_wr_data <= wr_data_next;
        end
    end

    // Pending B destination. It is captured while A is written, and reset discards it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_addr_reg <= '0;
            pend_data_reg <= '0;
        end else if (pend_load) begin
            pend_addr_reg <= reg_b_wr_addr_in;
            pend_data_reg <= hi_data_in;
        end
    end

`ifdef WB_FWD_EN
    // Forwarding view of the write in flight. The held B has priority over the port registers.
    always_comb begin
        fwd_valid = rf_wr_en || (state_reg == WRITE_B);
        fwd_addr  = rf_wr_addr;
        fwd_data  = rf_wr_data;
        if (state_reg == WRITE_B) begin
            fwd_addr = pend_addr_reg;
            fwd_data = pend_data_reg;
        end
    end
`endif

endmodule

// File: tb/tb_wb_write_sequencer.sv
// Self-checking bench for wb_write_sequencer. The reference model is a queue of
// register writes still owed to the register file. Each accepted slot appends
// its writes. Each clock retires one write. The DUT is ready exactly when
// nothing is owed.
module tb_wb_write_sequencer;
    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_in;
    logic          sel;
    logic [DW-1:0] alu_data;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] hi_data;
    logic [AW-1:0] a_addr;
    logic [AW-1:0] b_addr;
    logic          a_en;
    logic          b_en;
    logic          ready_out;
    logic          rf_wr_en;
    logic [AW-1:0] rf_wr_addr;
    logic [DW-1:0] rf_wr_data;
`ifdef WB_FWD_EN
    logic          fwd_valid;
    logic [AW-1:0] fwd_addr;
    logic [DW-1:0] fwd_data;
`endif

    wb_write_sequencer #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .valid_in              (valid_in),
        .write_back_mux_sel_in (sel),
        .alu_data_in           (alu_data),
        .mem_data_in           (mem_data),
        .hi_data_in            (hi_data),
        .reg_a_wr_addr_in      (a_addr),
        .reg_b_wr_addr_in      (b_addr),
        .reg_a_wr_en_in        (a_en),
        .reg_b_wr_en_in        (b_en),
        .ready_out             (ready_out),
        .rf_wr_en              (rf_wr_en),
        .rf_wr_addr            (rf_wr_addr),
        .rf_wr_data            (rf_wr_data)
`ifdef WB_FWD_EN
        ,
        .fwd_valid             (fwd_valid),
        .fwd_addr              (fwd_addr),
        .fwd_data              (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    wr_t           owed[$];
    logic          exp_en;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    logic          exp_ready;

    task automatic drive(input logic v, input logic s, input logic [DW-1:0] alu,
                         input logic [DW-1:0] mem, input logic [DW-1:0] hi,
                         input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                         input logic ae, input logic be);
        valid_in = v; sel = s; alu_data = alu; mem_data = mem; hi_data = hi;
        a_addr = aa; b_addr = ba; a_en = ae; b_en = be;
    endtask

    task automatic drive_idle();
        drive(1'b0, 1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic model_clear();
        owed.delete();
        exp_en = 1'b0; exp_addr = '0; exp_data = '0; exp_ready = 1'b1;
    endtask

    // Advance one clock. The model takes the slot if nothing is owed, then retires one write.
    task automatic step();
        wr_t wa;
        wr_t wb;
        wr_t w;
        logic do_a;
        logic do_b;
        if (owed.size() == 0 && valid_in) begin
            do_a = a_en && (a_addr != 0);
            do_b = b_en && (b_addr != 0);
            wa.a = a_addr; wa.d = sel ? mem_data : alu_data;
            wb.a = b_addr; wb.d = hi_data;
            if (do_a && !(do_b && a_addr == b_addr)) owed.push_back(wa);
            if (do_b) owed.push_back(wb);
        end
        if (owed.size() > 0) begin
            w = owed.pop_front();
            exp_en = 1'b1; exp_addr = w.a; exp_data = w.d;
        end else begin
            exp_en = 1'b0;
        end
        exp_ready = (owed.size() == 0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        model_clear();
        repeat (2) @(negedge clk);
        total++;
        if (rf_wr_en !== 1'b0 || rf_wr_addr !== '0 || rf_wr_data !== '0 || ready_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_state: en=%b addr=%0d data=%h ready=%b, required 0 0 0 1",
                     rf_wr_en, rf_wr_addr, rf_wr_data, ready_out);
        end
        rst = 1'b0;
        // Live traffic, then reset in the middle of a cycle.
        drive(1'b1, 1'b0, 32'h1234_5678, '0, '0, 5'd4, 5'd0, 1'b1, 1'b0);
        step();
        #2 rst = 1'b1;
        #1;
        model_clear();
        total++;
        if (rf_wr_en !== 1'b0 || rf_wr_addr !== '0 || rf_wr_data !== '0 || ready_out !== 1'b1) begin
            bad++;
            $display("FAIL reset_async: en=%b addr=%0d data=%h ready=%b, required 0 0 0 1",
                     rf_wr_en, rf_wr_addr, rf_wr_data, ready_out);
        end
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
    endtask

    task automatic test_a_only();
        drive(1'b1, 1'b1, 32'h1, 32'hDEAD_BEEF, 32'h0, 5'd3, 5'd0, 1'b1, 1'b0);
        step();
        drive_idle();
        total++;
        if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd3 || rf_wr_data !== 32'hDEAD_BEEF || ready_out !== 1'b1) begin
            bad++;
            $display("FAIL a_only: en=%b addr=%0d data=%h ready=%b, required 1 3 deadbeef 1",
                     rf_wr_en, rf_wr_addr, rf_wr_data, ready_out);
        end
        step();
        total++;
        if (rf_wr_en !== 1'b0 || rf_wr_addr !== 5'd3 || rf_wr_data !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL a_only_hold: en=%b addr=%0d data=%h, required 0 3 deadbeef",
                     rf_wr_en, rf_wr_addr, rf_wr_data);
        end
    endtask

    task automatic test_dual();
        drive(1'b1, 1'b0, 32'h11, 32'h99, 32'h22, 5'd5, 5'd6, 1'b1, 1'b1);
        step();
        // These inputs arrive during the stall, so the DUT must ignore them.
        drive(1'b1, 1'b0, 32'h77, 32'h0, 32'h0, 5'd8, 5'd0, 1'b1, 1'b0);
        total++;
        if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd5 || rf_wr_data !== 32'h11 || ready_out !== 1'b0) begin
            bad++;
            $display("FAIL dual_first: en=%b addr=%0d data=%h ready=%b, required 1 5 11 0",
                     rf_wr_en, rf_wr_addr, rf_wr_data, ready_out);
        end
`ifdef WB_FWD_EN
        total++;
        if (fwd_valid !== 1'b1 || fwd_addr !== 5'd6 || fwd_data !== 32'h22) begin
            bad++;
            $display("FAIL fwd_pending: valid=%b addr=%0d data=%h, required 1 6 22",
                     fwd_valid, fwd_addr, fwd_data);
        end
`endif
        step();
        drive_idle();
        total++;
        if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd6 || rf_wr_data !== 32'h22 || ready_out !== 1'b1) begin
            bad++;
            $display("FAIL dual_second: en=%b addr=%0d data=%h ready=%b, required 1 6 22 1",
                     rf_wr_en, rf_wr_addr, rf_wr_data, ready_out);
        end
        step();
        total++;
        if (rf_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL dual_ignored_stall_input: en=%b addr=%0d, required en 0", rf_wr_en, rf_wr_addr);
        end
    endtask

    task automatic test_same_addr();
        drive(1'b1, 1'b0, 32'h44, 32'h0, 32'h33, 5'd7, 5'd7, 1'b1, 1'b1);
        step();
        drive_idle();
        total++;
        if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd7 || rf_wr_data !== 32'h33 || ready_out !== 1'b1) begin
            bad++;
            $display("FAIL same_addr: en=%b addr=%0d data=%h ready=%b, required 1 7 33 1",
                     rf_wr_en, rf_wr_addr, rf_wr_data, ready_out);
        end
        step();
        total++;
        if (rf_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL same_addr_single: en=%b, required 0", rf_wr_en);
        end
    endtask

    task automatic test_r0();
        drive(1'b1, 1'b0, 32'h55, 32'h0, 32'h66, 5'd0, 5'd9, 1'b1, 1'b1);
        step();
        drive(1'b1, 1'b0, 32'h55, 32'h0, 32'h66, 5'd0, 5'd0, 1'b1, 1'b1);
        total++;
        if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd9 || rf_wr_data !== 32'h66 || ready_out !== 1'b1) begin
            bad++;
            $display("FAIL r0_a: en=%b addr=%0d data=%h ready=%b, required 1 9 66 1",
                     rf_wr_en, rf_wr_addr, rf_wr_data, ready_out);
        end
        step();
        drive_idle();
        total++;
        if (rf_wr_en !== 1'b0 || ready_out !== 1'b1) begin
            bad++;
            $display("FAIL r0_both: en=%b ready=%b, required 0 1", rf_wr_en, ready_out);
        end
    endtask

    task automatic test_reset_write_b();
        drive(1'b1, 1'b0, 32'h5A, 32'h0, 32'h6B, 5'd5, 5'd6, 1'b1, 1'b1);
        step();
        drive_idle();
        #2 rst = 1'b1;
        #1;
        model_clear();
        total++;
        if (ready_out !== 1'b1 || rf_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL rst_writeb: ready=%b en=%b, required 1 0", ready_out, rf_wr_en);
        end
        @(negedge clk);
        rst = 1'b0;
        step();
        total++;
        if (rf_wr_en !== 1'b0) begin
            bad++;
            $display("FAIL rst_writeb_lost_b: en=%b addr=%0d, required en 0", rf_wr_en, rf_wr_addr);
        end
        drive(1'b1, 1'b0, 32'hABCD, 32'h0, 32'h0, 5'd12, 5'd0, 1'b1, 1'b0);
        step();
        drive_idle();
        total++;
        if (rf_wr_en !== 1'b1 || rf_wr_addr !== 5'd12 || rf_wr_data !== 32'hABCD) begin
            bad++;
            $display("FAIL rst_writeb_new_slot: en=%b addr=%0d data=%h, required 1 12 abcd",
                     rf_wr_en, rf_wr_addr, rf_wr_data);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 32'h100 + i, 32'h0, 32'h200 + i, 5'(2 * i + 1), 5'(2 * i + 2), 1'b1, 1'b1);
            step();
            total++;
            if (rf_wr_en !== exp_en || rf_wr_addr !== exp_addr || rf_wr_data !== exp_data
                || ready_out !== exp_ready || ready_out !== 1'(i % 2 == 0 ? 0 : 1)) begin
                bad++;
                $display("FAIL back_to_back[%0d]: en=%b addr=%0d data=%h ready=%b, required %b %0d %h %b",
                         i, rf_wr_en, rf_wr_addr, rf_wr_data, ready_out, exp_en, exp_addr, exp_data, exp_ready);
            end
        end
        drive_idle();
        step();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 9) < 8), 1'($urandom), $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
            step();
            total++;
            if (rf_wr_en !== exp_en || rf_wr_addr !== exp_addr || rf_wr_data !== exp_data
                || ready_out !== exp_ready) begin
                bad++;
                $display("FAIL random[%0d]: en=%b addr=%0d data=%h ready=%b, required %b %0d %h %b",
                         i, rf_wr_en, rf_wr_addr, rf_wr_data, ready_out, exp_en, exp_addr, exp_data, exp_ready);
            end
`ifdef WB_FWD_EN
            total++;
            if (fwd_valid !== (exp_en || owed.size() > 0)
                || (owed.size() > 0 && (fwd_addr !== owed[0].a || fwd_data !== owed[0].d))
                || (owed.size() == 0 && (fwd_addr !== exp_addr || fwd_data !== exp_data))) begin
                bad++;
                $display("FAIL random_fwd[%0d]: valid=%b addr=%0d data=%h", i, fwd_valid, fwd_addr, fwd_data);
            end
`endif
        end
        drive_idle();
        step();
    endtask

    initial begin
        test_reset();
        test_a_only();
        test_dual();
        test_same_addr();
        test_r0();
        test_reset_write_b();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
